// File: rtl/fetch_unit.sv
// fetch_unit: PC / old PC / IR holder turning ir_write into a valid/ready instruction fetch.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky fetch_fault output for misaligned fetch PCs.
`default_nettype none

module fetch_unit #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ir_write,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            fetch_fault,
`endif
  output logic            fetch_stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_old_pc;
  logic [XLEN-1:0]   r_addr;
  logic [31:0]       r_instr;
  logic              r_req_valid;
  logic              r_stall;
  logic              w_misaligned;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              r_fault;
  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign fetch_fault  = r_fault;
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC[XLEN-1:0];
      r_old_pc    <= RESET_PC[XLEN-1:0];
      r_addr      <= '0;
      r_instr     <= NOP_INSTR;
      r_req_valid <= 1'b0;
      r_stall     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pc_write) begin
            r_pc <= pc_next;
          end
          if (ir_write) begin
            r_old_pc <= r_pc;
            if (w_misaligned) begin
`ifdef FETCH_MISALIGN_CHECK_EN
              r_fault <= 1'b1;
`endif
              r_instr <= NOP_INSTR;
            end else begin
              r_addr      <= r_pc;
              r_req_valid <= 1'b1;
              r_stall     <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (imem_req_ready) begin
            r_req_valid <= 1'b0;
            // Zero-latency memory: response accompanies the accepted request.
            if (imem_rsp_valid) begin
              r_instr <= imem_rsp_data;
              r_stall <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_instr <= imem_rsp_data;
            r_stall <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
          r_stall     <= 1'b0;
        end
      endcase
    end
  end

  assign pc             = r_pc;
  assign old_pc         = r_old_pc;
  assign instr          = r_instr;
  assign imem_addr      = r_addr;
  assign imem_req_valid = r_req_valid;
  assign fetch_stall    = r_stall;

  assign opcode = r_instr[6:0];
  assign funct3 = r_instr[14:12];
  assign funct7 = r_instr[31:25];
  assign rs1    = r_instr[19:15];
  assign rs2    = r_instr[24:20];
  assign rd     = r_instr[11:7];

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Holds the PC, the old PC and the instruction register for the multi-cycle RISC-V core.
- Sits between instruction memory and control_unit:
  - turns control_unit's ir_write/pc_write into a variable-latency memory fetch using a valid/ready handshake;
  - supplies decoded instruction fields back to control_unit.
- While a fetch is outstanding it asserts fetch_stall; the control FSM holds its state for that time.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- ir_write  in  1  from control_unit; start instruction fetch at current pc.
- pc_write  in  1  from control_unit; load pc from pc_next.
- pc_next  in  XLEN  result bus (ALU result / PC+4 / target).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address, stable while imem_req_valid.
- imem_rsp_valid  in  1  returned instruction valid.
- imem_rsp_data  in  32  returned instruction.
- pc  out  XLEN  current PC.
- old_pc  out  XLEN  PC of the instruction in the IR.
- instr  out  32  instruction register.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- rs1, rs2, rd  out  5 each  instr[19:15], instr[24:20], instr[11:7].
- fetch_stall  out  1  high while a fetch is outstanding.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, old_pc=RESET_PC, instr=NOP_INSTR.
  - imem_req_valid=0, imem_addr=0, fetch_stall=0, state=IDLE.
  - Release is synchronous to the next clk edge.
- Field outputs are purely combinational slices of instr.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - ir_write=1:
    - latch imem_addr<=pc and old_pc<=pc;
    - if pc_write=1 in the same cycle, pc<=pc_next (normally PC+4);
    - go to REQ; fetch_stall=1 from the next cycle.
  - ir_write=0, pc_write=1: pc<=pc_next (jumps and branches).
- REQ:
  - imem_req_valid=1, imem_addr held.
  - Handshake completes on the cycle where imem_req_valid && imem_req_ready → go to WAIT.
  - If imem_rsp_valid is also high in that cycle (zero-latency memory): capture instr<=imem_rsp_data and go directly to IDLE.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1: instr<=imem_rsp_data, go to IDLE.
- fetch_stall is a registered output: 1 in REQ and WAIT, 0 in IDLE. Minimum fetch latency is 2 cycles from ir_write to fetch_stall falling.
- While fetch_stall=1, pc_write and ir_write are ignored; pc, old_pc and instr are unchanged until capture.
- imem_rsp_valid seen in IDLE, or in REQ before the handshake, is ignored (instr unchanged).
- Reset asserted mid-fetch returns to IDLE immediately. A response arriving after reset release is ignored per the rule above.
- pc arithmetic: pc_next is loaded verbatim; no wrap logic, since XLEN-bit overflow wraps naturally.
- instr changes only on capture, so opcode and the other fields are stable through DECODE and all execute states.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - extra output fetch_fault (1 bit, reset 0).
  - On ir_write in IDLE with pc[1:0]!=0: no request is issued; fetch_fault<=1 (sticky until reset); instr<=NOP_INSTR; old_pc<=pc; FSM stays in IDLE; fetch_stall stays 0.
- Undefined: port absent; misaligned PCs are fetched as-is with imem_addr=pc.

Test Plan:
- Reset → pc=0, old_pc=0, instr=32'h00000013, opcode=7'b0010011, imem_req_valid=0, fetch_stall=0.
- ir_write=1, pc_write=1, pc_next=4; ready=1; response 32'h00500093 two cycles later:
  - imem_addr=0, old_pc=0, pc=4;
  - fetch_stall high 3 cycles;
  - instr=32'h00500093, rd=1, opcode=7'b0010011.
- imem_req_ready held low 5 cycles → imem_req_valid and imem_addr=0 stable for all 5; pc_write=1 with pc_next=32'h100 during stall → pc stays 4.
- IDLE, pc_write=1, pc_next=32'h80, ir_write=0 → pc=32'h80, no request; spurious imem_rsp_valid with 32'hDEADBEEF → instr unchanged.
- reset_n low during WAIT, response arrives after release → state IDLE, instr=NOP_INSTR, pc=RESET_PC.
- FETCH_MISALIGN_CHECK_EN defined, pc=32'h2, ir_write=1 → imem_req_valid stays 0, fetch_fault=1 sticky, instr=NOP_INSTR.
